// File: rtl/mem_stage.sv
// Memory-access pipeline stage: address decode and alignment checks, byte-lane stores,
// load extension, device-bus access and the Mem/WB pipeline register.
module mem_stage #(
    parameter int          DM_WORDS  = 4096,
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [3:0]  mem_op_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  reg_waddr_in,
    input  logic [2:0]  tnew_in,
    input  logic        err_in,
    input  logic [4:0]  err_stat_in,
    input  logic [31:0] dev_rdata,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev_we,
    output logic [4:0]  reg_waddr_mem,
    output logic [2:0]  tnew_mem,
    output logic        exc_mem,
    output logic [4:0]  exc_code_mem,
    output logic [31:0] pc_wb,
    output logic [4:0]  reg_waddr_wb,
    output logic [31:0] wb_data_wb,
    output logic [2:0]  tnew_wb,
    output logic        err_wb,
    output logic [4:0]  err_stat_wb
);

    localparam int          IDX_W    = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [31:0] dm [DM_WORDS];

    logic [31:0]      a;
    logic             in_dm, in_dev0, in_dev1, in_dev, illegal, dev_count_reg;
    logic             is_load, is_store, word_op, half_op, misaligned;
    logic             load_fault, store_fault, commit;
    logic [IDX_W-1:0] dm_idx;
    logic [31:0]      dm_word;
    logic [3:0]       byte_en;
    logic [31:0]      store_lanes;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      load_val;
    logic [31:0]      wb_data_next;

    assign a = alu_out_in;

    // Region decode; device windows are three words each.
    assign in_dm         = a < DM_BYTES;
    assign in_dev0       = (a >= DEV0_BASE) && (a < DEV0_BASE + 32'd12);
    assign in_dev1       = (a >= DEV1_BASE) && (a < DEV1_BASE + 32'd12);
    assign in_dev        = in_dev0 || in_dev1;
    assign illegal       = !in_dm && !in_dev;
    assign dev_count_reg = (a == DEV0_BASE + 32'd8) || (a == DEV1_BASE + 32'd8);

    assign is_load    = (mem_op_in >= OP_LW) && (mem_op_in <= OP_LBU);
    assign is_store   = (mem_op_in >= OP_SW) && (mem_op_in <= OP_SB);
    assign word_op    = (mem_op_in == OP_LW) || (mem_op_in == OP_SW);
    assign half_op    = (mem_op_in == OP_LH) || (mem_op_in == OP_LHU) || (mem_op_in == OP_SH);
    assign misaligned = (word_op && (a[1:0] != 2'b00)) || (half_op && a[0]);

    assign load_fault  = is_load && (misaligned || illegal || (in_dev && !word_op));
    assign store_fault = is_store && (misaligned || illegal ||
                                      (in_dev && (!word_op || dev_count_reg)));

    // An upstream exception masks any fault detected here.
    assign exc_mem      = err_in || load_fault || store_fault;
    assign exc_code_mem = err_in      ? err_stat_in :
                          load_fault  ? EXC_ADEL    :
                          store_fault ? EXC_ADES    : err_stat_in;

    assign commit = is_store && !exc_mem && !flush && !reset;

    assign dev_we    = commit && in_dev;
    assign dev_addr  = {a[31:2], 2'b00};
    assign dev_wdata = store_data_in;

    assign reg_waddr_mem = reg_waddr_in;
    assign tnew_mem      = (tnew_in != 3'd0) ? tnew_in - 3'd1 : 3'd0;

    assign dm_idx  = a[IDX_W+1:2];
    assign dm_word = dm[dm_idx];

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = store_data_in;
        case (mem_op_in)
            OP_SW: byte_en = 4'b1111;
            OP_SH: begin
                byte_en     = 4'b0011 << a[1:0];
                store_lanes = {2{store_data_in[15:0]}};
            end
            OP_SB: begin
                byte_en     = 4'b0001 << a[1:0];
                store_lanes = {4{store_data_in[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        half_sel = a[1] ? dm_word[31:16] : dm_word[15:0];
        byte_sel = dm_word[{a[1:0], 3'b000} +: 8];
        load_val = dm_word;
        case (mem_op_in)
            OP_LW:   load_val = in_dev ? dev_rdata : dm_word;
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: ;
        endcase
        wb_data_next = is_load ? (exc_mem ? 32'h0 : load_val) : alu_out_in;
    end

    // NOTE: the data memory has no reset; its contents survive reset and clearing it would need a per-word reset network.
    always_ff @(posedge clk) begin
        if (commit && in_dm) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) dm[dm_idx][8*i +: 8] <= store_lanes[8*i +: 8];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_wb        <= PC_RESET;
            reg_waddr_wb <= 5'd0;
            wb_data_wb   <= 32'h0;
            tnew_wb      <= 3'd0;
            err_wb       <= 1'b0;
            err_stat_wb  <= 5'd31;
        end else if (flush) begin
            pc_wb        <= PC_RESET;
            reg_waddr_wb <= 5'd0;
            wb_data_wb   <= 32'h0;
            tnew_wb      <= 3'd0;
            err_wb       <= 1'b0;
            err_stat_wb  <= 5'd31;
        end else begin
            pc_wb        <= pc_in;
            reg_waddr_wb <= exc_mem ? 5'd0 : reg_waddr_in;
            wb_data_wb   <= wb_data_next;
            tnew_wb      <= tnew_mem;
            err_wb       <= exc_mem;
            err_stat_wb  <= exc_code_mem;
        end
    end

endmodule
